// File: rtl/jamma_joy_mux.sv
// JAMMA-side responder of the two-player joystick split link: debounces all
// harness controls, muxes player data onto JJOY by JSELECT, stretches coins.
module jamma_joy_mux #(
  parameter int DB_BITS   = 16,
  parameter int COIN_MIN  = 65536,
  parameter int IDLE_BITS = 20
) (
  input  logic       clk_sys,
  input  logic       rst_b,
  input  logic       JSELECT,
  input  logic [7:0] P1_RAW,
  input  logic [7:0] P2_RAW,
  input  logic [1:0] COIN_RAW,
  input  logic       SERVICE_RAW,
  input  logic       TEST_RAW,
  output logic [7:0] JJOY,
  output logic [1:0] JCOIN,
  output logic       JSERVICE,
  output logic       JTEST,
  output logic       LINK_OK
);

  // Bit layout of the combined input vector: [7:0] P1, [15:8] P2,
  // [17:16] coins, [18] service, [19] test.
  localparam int N_IN = 20;
  localparam int CW   = (COIN_MIN > 1) ? $clog2(COIN_MIN) : 1;

  localparam logic [DB_BITS-1:0]   DB_MAX    = '1;
  localparam logic [IDLE_BITS-1:0] IDLE_MAX  = '1;
  localparam logic [CW-1:0]        COIN_LOAD = CW'(COIN_MIN - 1);

  logic [N_IN-1:0] raw_all;

  logic [N_IN-1:0] sync1_q, sync1_d;
  logic [N_IN-1:0] sync2_q, sync2_d;
  logic [N_IN-1:0] stable_q, stable_d;
  logic [N_IN-1:0][DB_BITS-1:0] db_cnt_q, db_cnt_d;
  logic [1:0][CW-1:0] coin_cnt_q, coin_cnt_d;

  logic jsel_s1_q, jsel_s1_d;
  logic jsel_s2_q, jsel_s2_d;
  logic jsel_dly_q, jsel_dly_d;
  logic jsel_edge;
  logic [IDLE_BITS-1:0] idle_cnt_q, idle_cnt_d;

  assign raw_all = {TEST_RAW, SERVICE_RAW, COIN_RAW, P2_RAW, P1_RAW};

  always_comb begin
    sync1_d    = raw_all;
    sync2_d    = sync1_q;
    stable_d   = stable_q;
    db_cnt_d   = db_cnt_q;
    coin_cnt_d = coin_cnt_q;
    jsel_s1_d  = JSELECT;
    jsel_s2_d  = jsel_s1_q;
    jsel_dly_d = jsel_s2_q;
    idle_cnt_d = idle_cnt_q;

    for (int i = 0; i < N_IN; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_MAX) begin
        stable_d[i] = sync2_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end

    // Load on the same edge the debounced coin falls so the stretch window
    // starts together with the debounced assertion.
    for (int j = 0; j < 2; j++) begin
      if (stable_q[16+j] && !stable_d[16+j]) begin
        coin_cnt_d[j] = COIN_LOAD;
      end else if (coin_cnt_q[j] != '0) begin
        coin_cnt_d[j] = coin_cnt_q[j] - 1'b1;
      end
    end

    jsel_edge = jsel_s2_q ^ jsel_dly_q;
    if (jsel_edge) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != IDLE_MAX) begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      stable_q   <= '1;
      db_cnt_q   <= '0;
      coin_cnt_q <= '0;
      jsel_s1_q  <= 1'b0;
      jsel_s2_q  <= 1'b0;
      jsel_dly_q <= 1'b0;
      idle_cnt_q <= IDLE_MAX;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      stable_q   <= stable_d;
      db_cnt_q   <= db_cnt_d;
      coin_cnt_q <= coin_cnt_d;
      jsel_s1_q  <= jsel_s1_d;
      jsel_s2_q  <= jsel_s2_d;
      jsel_dly_q <= jsel_dly_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  // JSELECT deliberately bypasses the synchronizer here: the master samples
  // JJOY in its own domain right after toggling the select.
  assign JJOY     = JSELECT ? stable_q[15:8] : stable_q[7:0];
  assign JCOIN[0] = stable_q[16] & (coin_cnt_q[0] == '0);
  assign JCOIN[1] = stable_q[17] & (coin_cnt_q[1] == '0);
  assign JSERVICE = stable_q[18];
  assign JTEST    = stable_q[19];
  assign LINK_OK  = (idle_cnt_q != IDLE_MAX);

endmodule

// File: tb/tb_jamma_joy_mux.sv
// Bench for jamma_joy_mux: window-based reference model checked every cycle,
// plus directed literal checks on latencies and boundaries.
module tb_jamma_joy_mux;

  localparam int DB_BITS   = 4;
  localparam int MAX       = 15;
  localparam int COIN_MIN  = 8;
  localparam int IDLE_BITS = 5;
  localparam int IDLE      = 31;

  logic       clk_sys;
  logic       rst_b;
  logic       JSELECT;
  logic [7:0] P1_RAW, P2_RAW;
  logic [1:0] COIN_RAW;
  logic       SERVICE_RAW, TEST_RAW;
  logic [7:0] JJOY;
  logic [1:0] JCOIN;
  logic       JSERVICE, JTEST, LINK_OK;

  int errors = 0;
  int checks = 0;

  jamma_joy_mux #(
    .DB_BITS(DB_BITS), .COIN_MIN(COIN_MIN), .IDLE_BITS(IDLE_BITS)
  ) dut (
    .clk_sys(clk_sys), .rst_b(rst_b), .JSELECT(JSELECT),
    .P1_RAW(P1_RAW), .P2_RAW(P2_RAW), .COIN_RAW(COIN_RAW),
    .SERVICE_RAW(SERVICE_RAW), .TEST_RAW(TEST_RAW),
    .JJOY(JJOY), .JCOIN(JCOIN), .JSERVICE(JSERVICE), .JTEST(JTEST),
    .LINK_OK(LINK_OK)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a debounced bit changes once the last MAX+1 synchronized
  // samples all disagree with it; synchronized = raw sampled two edges ago.
  logic [19:0] hist[$];
  logic        js_hist[$];
  logic [19:0] m_stable;
  int          k;
  int          fall_k[2];
  int          last_clr;
  bit          clr_seen;

  task automatic model_reset();
    k = 0;
    hist.delete();
    for (int i = 0; i < MAX + 3; i++) hist.push_back(20'hFFFFF);
    js_hist.delete();
    for (int i = 0; i < 4; i++) js_hist.push_back(1'b0);
    m_stable = 20'hFFFFF;
    fall_k[0] = -1000;
    fall_k[1] = -1000;
    last_clr = -1000;
    clr_seen = 0;
  endtask

  always @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      model_reset();
    end else begin
      logic [19:0] prev;
      k++;
      hist.push_back({TEST_RAW, SERVICE_RAW, COIN_RAW, P2_RAW, P1_RAW});
      void'(hist.pop_front());
      prev = m_stable;
      for (int b = 0; b < 20; b++) begin
        bit all_eq;
        all_eq = 1;
        for (int w = 1; w <= MAX; w++)
          if (hist[w][b] != hist[0][b]) all_eq = 0;
        if (all_eq && hist[0][b] != m_stable[b]) m_stable[b] = hist[0][b];
      end
      for (int j = 0; j < 2; j++)
        if (prev[16+j] && !m_stable[16+j]) fall_k[j] = k;
      js_hist.push_back(JSELECT);
      void'(js_hist.pop_front());
      if (js_hist[1] != js_hist[0]) begin
        last_clr = k;
        clr_seen = 1;
      end
    end
  end

  always @(negedge clk_sys) begin
    logic [7:0] e_joy;
    logic [1:0] e_coin;
    logic       e_link;
    e_joy = JSELECT ? m_stable[15:8] : m_stable[7:0];
    for (int j = 0; j < 2; j++)
      e_coin[j] = m_stable[16+j] & (k >= fall_k[j] + COIN_MIN - 1);
    e_link = clr_seen && (k - last_clr < IDLE);
    chk("m_jjoy", JJOY, e_joy);
    chk("m_jcoin", JCOIN, e_coin);
    chk("m_jservice", JSERVICE, m_stable[18]);
    chk("m_jtest", JTEST, m_stable[19]);
    chk("m_link_ok", LINK_OK, e_link);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_sys);
    #2;
  endtask

  initial begin
    rst_b = 1'b0; JSELECT = 1'b0;
    P1_RAW = 8'hFF; P2_RAW = 8'hFF; COIN_RAW = 2'b11;
    SERVICE_RAW = 1'b1; TEST_RAW = 1'b1;
    step(3);
    chk("rst_jjoy", JJOY, 8'hFF);
    chk("rst_jcoin", JCOIN, 2'b11);
    chk("rst_link", LINK_OK, 1'b0);
    chk("rst_service", JSERVICE, 1'b1);

    rst_b = 1'b1;
    P1_RAW = 8'hFE;
    step(17); chk("p1_edge17", JJOY, 8'hFF);
    step(1);  chk("p1_edge18", JJOY, 8'hFE);
    JSELECT = 1'b1; #1 chk("sel_p2_comb", JJOY, 8'hFF);
    JSELECT = 1'b0; #1 chk("sel_p1_comb", JJOY, 8'hFE);

    JSELECT = 1'b1;
    for (int r = 0; r < 4; r++) begin
      P2_RAW[7] = 1'b0; step(12);
      P2_RAW[7] = 1'b1; step(10);
    end
    chk("p2_glitch", JJOY, 8'hFF);
    P2_RAW[7] = 1'b0;
    step(17); chk("p2_edge17", JJOY, 8'hFF);
    step(1);  chk("p2_edge18", JJOY, 8'h7F);

    COIN_RAW = 2'b10;
    step(17); chk("coin_edge17", JCOIN, 2'b11);
    step(1);  chk("coin_edge18", JCOIN, 2'b10);
    step(2);
    COIN_RAW = 2'b11;
    step(17); chk("coin_hold", JCOIN, 2'b10);
    step(1);  chk("coin_release", JCOIN, 2'b11);

    step(35); chk("link_idle", LINK_OK, 1'b0);
    SERVICE_RAW = 1'b0; TEST_RAW = 1'b0; COIN_RAW = 2'b01;
    for (int i = 0; i < 40; i++) begin
      JSELECT = ~JSELECT;
      step(1);
      if (i == 1) chk("link_edge2", LINK_OK, 1'b0);
      if (i == 2) chk("link_edge3", LINK_OK, 1'b1);
    end
    step(32); chk("link_last30", LINK_OK, 1'b1);
    step(1);  chk("link_drop31", LINK_OK, 1'b0);
    SERVICE_RAW = 1'b1; TEST_RAW = 1'b1; COIN_RAW = 2'b11;
    step(25);

    JSELECT = 1'b0;
    P1_RAW = 8'hFC;
    step(12);
    #1 rst_b = 1'b0;
    #1 chk("midrst_jjoy", JJOY, 8'hFF);
    chk("midrst_link", LINK_OK, 1'b0);
    chk("midrst_jcoin", JCOIN, 2'b11);
    step(2);
    rst_b = 1'b1;
    step(17); chk("rerun_edge17", JJOY, 8'hFF);
    step(1);  chk("rerun_edge18", JJOY, 8'hFC);
    step(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
